// File: rtl/map_probe_if.sv
// Probe request/result bundle between movement logic, map_probe and the shared map ROM.
// The master drives the request and supplies the combinational ROM bit for map_addr.
interface map_probe_if;
    logic       start;
    logic [7:0] px;
    logic [6:0] py;
    logic [7:0] map_addr;
    logic       map_data;
    logic       busy;
    logic       done;
    logic       blocked;
    logic [1:0] hit_corner;

    modport master (
        output start, px, py, map_data,
        input  map_addr, busy, done, blocked, hit_corner
    );

    modport slave (
        input  start, px, py, map_data,
        output map_addr, busy, done, blocked, hit_corner
    );
endinterface

// File: rtl/map_probe.sv
// Pixel-to-tile probe: checks the four corners of a SIZE x SIZE footprint against the map ROM.
// Define MAP_PROBE_EARLY_EXIT_EN to stop at the first blocking corner instead of probing all four.
module map_probe #(
    parameter int SIZE = 7,
    parameter int X0   = 21,
    parameter int Y0   = 1,
    parameter int TILE = 9,
    parameter int GRID = 16
) (
    input  logic        clk,
    input  logic        resetn,
    map_probe_if.slave  bus
);

`ifdef MAP_PROBE_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [8:0] X_LO   = 9'(X0);
    localparam logic [8:0] X_HI   = 9'(X0 + TILE * GRID);
    localparam logic [7:0] Y_LO   = 8'(Y0);
    localparam logic [7:0] Y_HI   = 8'(Y0 + TILE * GRID);
    localparam logic [8:0] OFF_X  = 9'(SIZE - 1);
    localparam logic [7:0] OFF_Y  = 8'(SIZE - 1);
    localparam logic [7:0] TILE_W = 8'(TILE);

    typedef enum logic [2:0] {IDLE, LOAD, DIV, READ, DONE} state_t;

    state_t     state, state_nx;
    logic [7:0] px_q;
    logic [6:0] py_q;
    logic [1:0] corner;
    logic [7:0] rx, ry;
    logic [3:0] qx, qy;
    logic [7:0] map_addr_q;
    logic       blocked_q;
    logic [1:0] hit_q;

    logic [8:0] cx;
    logic [7:0] cy;
    logic       out_field, div_done, corner_block, advance, last_corner;

    // Corner 0..3 = TL, TR, BL, BR: bit 0 selects the right edge, bit 1 the bottom edge.
    always_comb begin
        cx           = {1'b0, px_q} + (corner[0] ? OFF_X : 9'd0);
        cy           = {1'b0, py_q} + (corner[1] ? OFF_Y : 8'd0);
        out_field    = (cx < X_LO) || (cx >= X_HI) || (cy < Y_LO) || (cy >= Y_HI);
        div_done     = (rx < TILE_W) && (ry < TILE_W);
        advance      = ((state == LOAD) && out_field) || (state == READ);
        corner_block = ((state == LOAD) && out_field) || ((state == READ) && bus.map_data);
        last_corner  = (corner == 2'd3) || (EARLY_EXIT && corner_block);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            IDLE: if (bus.start) state_nx = LOAD;
            LOAD: begin
                bus.busy = 1'b1;
                if (!out_field)      state_nx = DIV;
                else if (last_corner) state_nx = DONE;
                else                  state_nx = LOAD;
            end
            DIV: begin
                bus.busy = 1'b1;
                if (div_done) state_nx = READ;
            end
            READ: begin
                bus.busy = 1'b1;
                state_nx = last_corner ? DONE : LOAD;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all of them see the same pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            px_q       <= '0;
            py_q       <= '0;
            corner     <= '0;
            rx         <= '0;
            ry         <= '0;
            qx         <= '0;
            qy         <= '0;
            map_addr_q <= '0;
            blocked_q  <= 1'b0;
            hit_q      <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    px_q      <= bus.px;
                    py_q      <= bus.py;
                    corner    <= '0;
                    blocked_q <= 1'b0;
                    hit_q     <= '0;
                end
                LOAD: if (!out_field) begin
                    rx <= 8'(cx - X_LO);
                    ry <= cy - Y_LO;
                    qx <= '0;
                    qy <= '0;
                end
                DIV: begin
                    if (div_done) begin
                        map_addr_q <= {qx, qy};
                    end else begin
                        if (rx >= TILE_W) begin
                            rx <= rx - TILE_W;
                            qx <= qx + 4'd1;
                        end
                        if (ry >= TILE_W) begin
                            ry <= ry - TILE_W;
                            qy <= qy + 4'd1;
                        end
                    end
                end
                default: ;
            endcase

            // Only the first blocking corner is recorded.
            if (corner_block && !blocked_q) begin
                blocked_q <= 1'b1;
                hit_q     <= corner;
            end
            if (advance && !last_corner) corner <= corner + 2'd1;
        end
    end

    assign bus.map_addr   = map_addr_q;
    assign bus.blocked    = blocked_q;
    assign bus.hit_corner = hit_q;

endmodule

// File: doc/map_probe.md
Name: map_probe

Overview:
- Pixel-to-tile decoder for the battlefield map; the inverse of the tile-to-pixel map drawer.
- Takes a SIZE×SIZE sprite footprint at pixel (px,py), converts each of its four corners to a 16×16 tile address, and reads the shared map ROM.
- Reports whether any corner lands on a brick or outside the field.
- Used by tank and bullet movement logic before committing a move.

Parameters:
- SIZE, 7: footprint edge in pixels; corners are px / px+SIZE-1 and py / py+SIZE-1.
- X0, 21: pixel x of tile column 0.
- Y0, 1: pixel y of tile row 0.
- TILE, 9: tile pitch in pixels.
- GRID, 16: tiles per axis.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  request pulse; sampled only when busy=0
- px  in  8  footprint left pixel x
- py  in  7  footprint top pixel y
- map_addr  out  8  ROM address {tile_x[3:0], tile_y[3:0]}, same packing as the map drawer
- map_data  in  1  combinational ROM bit; 1 = brick
- busy  out  1  probe in progress
- done  out  1  one-cycle completion pulse
- blocked  out  1  result; valid from done, held until the next accepted start
- hit_corner  out  2  first blocking corner: 0=TL, 1=TR, 2=BL, 3=BR; 0 if not blocked

Behaviour:
- Reset (async, resetn=0):
  - State goes to IDLE.
  - busy, done, blocked, hit_corner, map_addr all go to 0.
  - Deasserting reset mid-probe leaves the block in IDLE; there is no resumption.
- States: IDLE, LOAD, DIV, READ, DONE.
- IDLE:
  - start=1 latches px and py, sets corner=0, clears blocked and hit_corner, goes to LOAD, and sets busy=1 from the next cycle.
  - start while busy=1 is ignored; it is neither queued nor latched.
- LOAD (1 cycle): forms the corner coordinate with 9-bit x and 8-bit y arithmetic.
  - If cx<X0, cx>=X0+TILE*GRID (165), cy<Y0, or cy>=Y0+TILE*GRID (145), the corner is out-of-field and counts as a block. Go to NEXT handling; no ROM read.
  - Otherwise load rx=cx-X0, ry=cy-Y0, qx=qy=0, and go to DIV.
- DIV: one step per cycle on both axes in parallel.
  - If rx>=TILE then rx-=TILE and qx++; likewise for y.
  - When both rx<TILE and ry<TILE at the start of a cycle, go to READ.
  - DIV length is max(qx,qy)+1 cycles.
- READ (1 cycle):
  - map_addr={qx[3:0],qy[3:0]}; map_addr holds its last value outside READ.
  - map_data is sampled at the end of READ; 1 is a block.
- NEXT handling (end of LOAD on out-of-field, or end of READ):
  - On a block with blocked still 0: set blocked=1 and hit_corner=corner.
  - If early-exit applies (see Optional Feature) or corner==3, go to DONE.
  - Otherwise corner++ and go to LOAD.
- DONE (1 cycle): done=1, busy=0 in this cycle, then IDLE. A start in the DONE cycle is ignored.
- Per-corner cost: out-of-field corner = 1 cycle; in-field corner = 1 + (max(qx,qy)+1) + 1 cycles.
- Corners are probed in order TL, TR, BL, BR.

Optional Feature:
- Macro: MAP_PROBE_EARLY_EXIT_EN.
- Defined: the probe goes to DONE immediately after the first blocking corner; remaining corners are skipped.
- Undefined: all four corners are always probed; blocked is the OR of all corners and hit_corner is the lowest-index blocking corner. blocked and hit_corner values are identical either way; only latency differs.

Test Plan:
- px=21, py=1, map all zero -> all corners in tile 0x00.
  - map_addr=0x00 on each READ; each corner costs 3 cycles, so busy is high 12 cycles.
  - done pulses once; blocked=0, hit_corner=0.
- px=66, py=46, map bit 0x55=1, others 0 -> TL maps to tile (5,5) with DIV 6 cycles and map_addr=0x55.
  - blocked=1, hit_corner=0.
  - With EARLY_EXIT, busy is high 8 cycles; without it, 32 cycles.
- px=20, py=1 -> TL out-of-field; no READ for TL.
  - blocked=1, hit_corner=0.
  - With EARLY_EXIT, busy is high 1 cycle.
- px=160, py=1, map zero -> TR cx=166 is out-of-field.
  - blocked=1, hit_corner=1; TL reads map_addr=0xF0.
- Assert start again while busy=1 with different px -> ignored; the result matches the first request.
- Pulse resetn=0 mid-DIV -> busy, done, blocked, map_addr all 0 immediately.
  - No done pulse follows; a fresh start afterwards completes normally.
